// File: rtl/fp16_add_pkg.sv
// fp16_add_pkg
// Shared definitions for the FP16 adder pipeline inside the systolic-array
// MAC unit. This package provides:
//   - the field widths of a binary16 value and of the internal fraction
//   - the all-ones exponent code used for infinity
//   - fp16_t: a packed view of a binary16 word
//   - norm_s1_t: what the normalize stage hands to the round/pack stage
// It has no ports.
package fp16_add_pkg;

  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  // Incoming fraction layout is {hidden, mant[9:0], guard, sticky}.
  localparam int FRAC_W = 13;

  localparam logic [EXP_W-1:0] EXP_INF = 5'h1F;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp16_t;

  // The exponent carries one extra bit so that the carry increment and the
  // rounding increment can reach 31 or 32 without wrapping back to a small
  // value.
  typedef struct packed {
    logic              sign;
    logic [EXP_W:0]    exp;
    logic [FRAC_W-1:0] frac;
    logic              zero;
    logic              inf;
  } norm_s1_t;

endpackage

// File: rtl/lzc_13b.sv
// lzc_13b
// Combinational leading-zero counter for the 13-bit adder fraction.
// Ports:
//   value    in  13  fraction to scan, MSB first
//   count    out 4   number of zeros above the first set bit (13 when all zero)
//   all_zero out 1   high when value is zero
module lzc_13b (
  input  logic [12:0] value,
  output logic [3:0]  count,
  output logic        all_zero
);

  // Walk from the MSB downward and latch the position of the first one seen.
  always_comb begin
    logic found;
    count    = 4'd13;
    all_zero = (value == 13'd0);
    found    = 1'b0;
    for (int i = 12; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = 4'(12 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp16_add_normalize.sv
// fp16_add_normalize
// This is the final stage of the FP16 adder. It takes the magnitude sum and
// turns it into a packed binary16 result in two pipeline stages:
//   - Stage 1 normalizes the sum.
//   - Stage 2 rounds to nearest-even and packs the result.
// Both sides use valid/ready handshakes. A stalled output never loses data
// and never duplicates data.
// Optional build macro FP16_ADD_FLAGS_EN adds the flags output
// {overflow, underflow, inexact}. The flags are registered with result.
// Ports:
//   clk        in  1   clock, rising edge
//   rst        in  1   asynchronous active-high reset
//   in_valid   in  1   upstream result valid
//   in_ready   out 1   stage can accept this cycle
//   sign_in    in  1   sign of the sum
//   sum_in     in  13  magnitude {h, m[9:0], g, s}
//   carry_in   in  1   overflow bit above sum_in[12]
//   exp_max_in in  5   larger operand exponent (0 when the sum is zero)
//   out_valid  out 1   result valid
//   out_ready  in  1   downstream accepts
//   result     out 16  packed FP16 {sign, exp[4:0], mant[9:0]}
//   flags      out 3   {overflow, underflow, inexact}, only with FP16_ADD_FLAGS_EN
module fp16_add_normalize
  import fp16_add_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [FRAC_W-1:0] sum_in,
  input  logic              carry_in,
  input  logic [EXP_W-1:0]  exp_max_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       result
`ifdef FP16_ADD_FLAGS_EN
  ,
  output logic [2:0]        flags
`endif
);

  logic     s1_valid;
  logic     s2_valid;
  logic     adv1;
  logic     adv2;
  norm_s1_t s1_next;
  norm_s1_t s1_q;
  fp16_t    pack_next;
  fp16_t    result_q;

  logic [3:0]        lz;
  logic              sum_zero;
  logic [FRAC_W-1:0] sum_shifted;

  logic [MANT_W:0]   mant_rnd;
  logic [EXP_W:0]    exp_rnd;
  logic              round_inc;
  logic              is_zero;
  logic              is_inf;

  // Each stage may advance when it is empty or when the stage after it drains
  // this cycle. Because of this, a full pipeline still moves one item per
  // cycle. The ready path comes only from out_ready, never from in_valid.
  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;
  assign result    = result_q;

  lzc_13b u_lzc (
    .value    (sum_in),
    .count    (lz),
    .all_zero (sum_zero)
  );

  assign sum_shifted = sum_in << lz;

`ifdef FP16_ADD_FLAGS_EN
  logic       s1_uflow_next;
  logic       s1_uflow_q;
  logic [2:0] flags_next;
  logic [2:0] flags_q;

  assign flags = flags_q;
`endif

  // Normalize.
  // An input exponent of 31 means the operands were already infinite, so the
  // result is forced to infinity.
  // A carry out of the adder is fixed by a one-bit right shift. The bit shifted
  // out becomes the guard bit, and the old guard and sticky bits merge into
  // the new sticky bit.
  // Any other nonzero sum is shifted left until its top bit is set. If the
  // exponent cannot absorb that shift, the result is flushed to zero.
  always_comb begin
    s1_next      = '0;
    s1_next.sign = sign_in;
`ifdef FP16_ADD_FLAGS_EN
    s1_uflow_next = 1'b0;
`endif
    if (exp_max_in == EXP_INF) begin
      s1_next.inf = 1'b1;
      s1_next.exp = {1'b0, EXP_INF};
    end else if (carry_in) begin
      s1_next.frac = {1'b1, sum_in[12:3], sum_in[2], |sum_in[1:0]};
      s1_next.exp  = {1'b0, exp_max_in} + 6'd1;
    end else if (sum_zero) begin
      s1_next.zero = 1'b1;
    end else if ({1'b0, exp_max_in} <= {2'b00, lz}) begin
      s1_next.zero = 1'b1;
`ifdef FP16_ADD_FLAGS_EN
      s1_uflow_next = 1'b1;
`endif
    end else begin
      s1_next.frac = sum_shifted;
      s1_next.exp  = {1'b0, exp_max_in} - {2'b00, lz};
    end
  end

  // Round to nearest-even, then pack.
  // Rounding increments the 10-bit mantissa. If that carries out, the value
  // reached 2.0, so the mantissa becomes zero and the exponent goes up by one.
  // A hidden bit that is clear outside the infinity path can only come from a
  // zero sum. Every zero result packs as +0.
  always_comb begin
    round_inc = s1_q.frac[1] & (s1_q.frac[0] | s1_q.frac[2]);
    mant_rnd  = {1'b0, s1_q.frac[11:2]} + {{MANT_W{1'b0}}, round_inc};
    exp_rnd   = s1_q.exp + {{EXP_W{1'b0}}, mant_rnd[MANT_W]};
    is_zero   = s1_q.zero || (!s1_q.inf && !s1_q.frac[12]);
    is_inf    = s1_q.inf || (exp_rnd >= 6'd31);
    pack_next = '0;
    if (is_zero) begin
      pack_next = '0;
    end else if (is_inf) begin
      pack_next.sign = s1_q.sign;
      pack_next.exp  = EXP_INF;
    end else begin
      pack_next.sign = s1_q.sign;
      pack_next.exp  = exp_rnd[EXP_W-1:0];
      pack_next.mant = mant_rnd[MANT_W-1:0];
    end
  end

`ifdef FP16_ADD_FLAGS_EN
  // Overflow and underflow both imply the value was not representable, so
  // either one also raises inexact.
  always_comb begin
    flags_next    = 3'b000;
    flags_next[2] = !is_zero && is_inf;
    flags_next[1] = s1_uflow_q;
    flags_next[0] = (|s1_q.frac[1:0]) || flags_next[2] || flags_next[1];
  end
`endif

  // Stage 1 register. It loads only on an accepted transfer, so an empty
  // bubble never overwrites stored data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q <= s1_next;
      end
    end
  end

  // Stage 2 register. It drives the outputs. It holds its value whenever a
  // valid result is waiting on a stalled consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      result_q <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result_q <= pack_next;
      end
    end
  end

`ifdef FP16_ADD_FLAGS_EN
  // Flag side-band registers. They follow the same enables as the data
  // registers so the flags stay aligned with their result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_uflow_q <= 1'b0;
      flags_q    <= 3'b000;
    end else begin
      if (adv1 && in_valid) begin
        s1_uflow_q <= s1_uflow_next;
      end
      if (adv2 && s1_valid) begin
        flags_q <= flags_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp16_add_normalize.sv
// tb_fp16_add_normalize
// Self-checking bench for fp16_add_normalize using directed vectors with
// hand-computed FP16 results. Build with FP16_ADD_FLAGS_EN to also check flags.
module tb_fp16_add_normalize;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [12:0] sum_in;
  logic        carry_in;
  logic [4:0]  exp_max_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
`ifdef FP16_ADD_FLAGS_EN
  logic [2:0]  flags;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        sign;
    logic        carry;
    logic [12:0] sum;
    logic [4:0]  exp;
    logic [15:0] res;
    logic [2:0]  flg;
  } vec_t;

  fp16_add_normalize dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign_in    (sign_in),
    .sum_in     (sum_in),
    .carry_in   (carry_in),
    .exp_max_in (exp_max_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result)
`ifdef FP16_ADD_FLAGS_EN
    ,
    .flags      (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, need $finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sign_in = 1'b0; sum_in = '0; carry_in = 1'b0; exp_max_in = '0;
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_out_valid: got %b need 0", out_valid);
    end
    compared++;
    if (result !== 16'h0000) begin
      mismatched++; $display("[TB] FAIL reset_result: got %h need 0000", result);
    end
`ifdef FP16_ADD_FLAGS_EN
    compared++;
    if (flags !== 3'b000) begin
      mismatched++; $display("[TB] FAIL reset_flags: got %b need 000", flags);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL reset_in_ready: got %b need 1", in_ready);
    end
  endtask

  // One input, out_ready held high. The result must appear exactly two edges
  // after the input is accepted.
  task automatic run_vector(input int idx, input vec_t v);
    @(negedge clk);
    in_valid = 1'b1; sign_in = v.sign; carry_in = v.carry;
    sum_in = v.sum; exp_max_in = v.exp; out_ready = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL vec%0d_in_ready: got %b need 1", idx, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL vec%0d_early_valid: got %b need 0", idx, out_valid);
    end
    @(negedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++; $display("[TB] FAIL vec%0d_latency: got out_valid %b need 1", idx, out_valid);
    end
    compared++;
    if (result !== v.res) begin
      mismatched++; $display("[TB] FAIL vec%0d_result: got %h need %h", idx, result, v.res);
    end
`ifdef FP16_ADD_FLAGS_EN
    compared++;
    if (flags !== v.flg) begin
      mismatched++; $display("[TB] FAIL vec%0d_flags: got %b need %b", idx, flags, v.flg);
    end
`endif
  endtask

  task automatic test_arith();
    vec_t v[15];
    v[0]  = '{1'b0, 1'b1, 13'h0000, 5'd15, 16'h4000, 3'b000}; // 1.0 + 1.0
    v[1]  = '{1'b0, 1'b0, 13'h0400, 5'd15, 16'h3400, 3'b000}; // cancellation, lz=2
    v[2]  = '{1'b0, 1'b0, 13'h1003, 5'd15, 16'h3C01, 3'b001}; // round up
    v[3]  = '{1'b0, 1'b0, 13'h1002, 5'd15, 16'h3C00, 3'b001}; // tie, even kept
    v[4]  = '{1'b0, 1'b0, 13'h1006, 5'd15, 16'h3C02, 3'b001}; // tie, odd up
    v[5]  = '{1'b1, 1'b1, 13'h0000, 5'd30, 16'hFC00, 3'b101}; // carry overflow
    v[6]  = '{1'b1, 1'b0, 13'h0010, 5'd3,  16'h0000, 3'b011}; // FTZ, +0
    v[7]  = '{1'b1, 1'b0, 13'h0000, 5'd0,  16'h0000, 3'b000}; // exact zero
    v[8]  = '{1'b0, 1'b0, 13'h1000, 5'd31, 16'h7C00, 3'b101}; // infinite input
    v[9]  = '{1'b0, 1'b0, 13'h1FFE, 5'd15, 16'h4000, 3'b001}; // round to 2.0
    v[10] = '{1'b0, 1'b0, 13'h1FFE, 5'd30, 16'h7C00, 3'b101}; // round into inf
    v[11] = '{1'b1, 1'b0, 13'h1000, 5'd15, 16'hBC00, 3'b000}; // -1.0
    v[12] = '{1'b0, 1'b1, 13'h000C, 5'd15, 16'h4002, 3'b001}; // carry + round
    v[13] = '{1'b0, 1'b0, 13'h0400, 5'd3,  16'h0400, 3'b000}; // smallest normal
    v[14] = '{1'b0, 1'b0, 13'h0400, 5'd2,  16'h0000, 3'b011}; // exp == lz flushes
    for (int i = 0; i < 15; i++) begin
      run_vector(i, v[i]);
    end
  endtask

  // Four inputs on consecutive cycles. The results must come out on four
  // consecutive cycles.
  task automatic test_back_to_back();
    logic [12:0] sums [4];
    logic [15:0] ress [4];
    sums = '{13'h1000, 13'h0400, 13'h1003, 13'h1006};
    ress = '{16'h3C00, 16'h3400, 16'h3C01, 16'h3C02};
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1; carry_in = 1'b0; sign_in = 1'b0; exp_max_in = 5'd15;
      in_valid = (cyc < 4);
      sum_in = sums[cyc % 4];
      #1;
      if (cyc < 4) begin
        compared++;
        if (in_ready !== 1'b1) begin
          mismatched++; $display("[TB] FAIL b2b_in_ready%0d: got %b need 1", cyc, in_ready);
        end
      end
      if (cyc >= 2 && cyc < 6) begin
        compared++;
        if (out_valid !== 1'b1 || result !== ress[cyc-2]) begin
          mismatched++;
          $display("[TB] FAIL b2b_out%0d: got valid %b result %h need 1 %h",
                   cyc - 2, out_valid, result, ress[cyc-2]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Hold out_ready low for three cycles while four inputs are offered. The
  // results must come out in order, unchanged, with none duplicated.
  task automatic test_backpressure();
    logic [12:0] sums  [4];
    logic        carrs [4];
    logic [15:0] ress  [4];
    logic        rdy_exp [3];
    logic [15:0] exp_q [$];
    logic [15:0] held;
    logic        held_valid;
    int          sent;
    int          got;
    int          idx;
    sums    = '{13'h1000, 13'h0400, 13'h0000, 13'h1003};
    carrs   = '{1'b0, 1'b0, 1'b1, 1'b0};
    ress    = '{16'h3C00, 16'h3400, 16'h4000, 16'h3C01};
    rdy_exp = '{1'b1, 1'b1, 1'b0};
    sent = 0; got = 0; held = '0; held_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      idx = (sent < 4) ? sent : 0;
      in_valid = (sent < 4);
      sign_in = 1'b0; exp_max_in = 5'd15;
      sum_in = sums[idx]; carry_in = carrs[idx];
      #1;
      if (cyc < 3) begin
        compared++;
        if (in_ready !== rdy_exp[cyc]) begin
          mismatched++;
          $display("[TB] FAIL bp_in_ready%0d: got %b need %b", cyc, in_ready, rdy_exp[cyc]);
        end
      end
      if (held_valid) begin
        compared++;
        if (out_valid !== 1'b1 || result !== held) begin
          mismatched++;
          $display("[TB] FAIL bp_hold: got valid %b result %h need 1 %h", out_valid, result, held);
        end
      end
      if (out_valid && out_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++; $display("[TB] FAIL bp_extra: got result %h need none", result);
        end else begin
          held = exp_q.pop_front();
          if (result !== held) begin
            mismatched++; $display("[TB] FAIL bp_order%0d: got %h need %h", got, result, held);
          end
        end
        got++;
      end
      held_valid = out_valid && !out_ready;
      held = result;
      if (in_valid && in_ready) begin
        exp_q.push_back(ress[sent]);
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    compared++;
    if (got != 4 || exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL bp_count: got %0d results (%0d pending) need 4 (0)", got, exp_q.size());
    end
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL bp_dup: got out_valid %b need 0", out_valid);
    end
  endtask

  // Assert reset while a result is stalled at the output. The output must
  // clear immediately, and no stale result may come out after release.
  task automatic test_reset_midstream();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; sign_in = 1'b0; carry_in = 1'b0;
    sum_in = 13'h1000; exp_max_in = 5'd15;
    @(negedge clk);
    in_valid = 1'b1; sum_in = 13'h0400;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b1 || result !== 16'h3C00) begin
      mismatched++;
      $display("[TB] FAIL rst_setup: got valid %b result %h need 1 3c00", out_valid, result);
    end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (out_valid !== 1'b0 || result !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL rst_async: got valid %b result %h need 0 0000", out_valid, result);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      compared++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL rst_stale%0d: got valid %b ready %b need 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
